store_write_buffer: RTL and testbench
=====================================

# store_write_buffer

Write-through store buffer between the D-cache store path and the shared `memory4c` port; it is the cache-to-memory counterpart of `cache_fill_FSM`, which moves data memory-to-cache. Stores from the EXMEM stage are queued as address/data pairs. They drain to memory one word per cycle whenever `mem_arb` grants the port. Pending entries are searched so a load never reads stale memory, and a flush handshake empties the buffer before a context or halt.

## Interface
- `DEPTH`, 4, number of entries (power of two, ≥2)
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: asynchronous, active-high reset
- `st_valid` in 1: store request from EXMEM (write-through store)
- `st_addr` in ADDR_W: store address
- `st_data` in DATA_W: store data
- `st_ready` out 1: store accepted this cycle when high with `st_valid`
- `mem_req` out 1: buffer holds ≥1 entry, requests port from `mem_arb`
- `mem_grant` in 1: arbiter grants memory port this cycle
- `mem_en` out 1: memory enable for the drain write
- `mem_wr` out 1: memory write strobe
- `mem_addr` out ADDR_W: head entry address
- `mem_wdata` out DATA_W: head entry data
- `ld_addr` in ADDR_W: address of load being looked up
- `ld_hit` out 1: a pending entry matches `ld_addr`
- `ld_data` out DATA_W: data of youngest matching entry
- `flush_req` in 1: one-cycle pulse, drain everything
- `flush_done` out 1: one-cycle pulse, buffer empty after flush
- `empty` out 1: count == 0
- `count` out clog2(DEPTH+1): occupied entries

## Operation
- Circular FIFO: `wr_ptr`, `rd_ptr` (clog2(DEPTH) bits, wrap modulo DEPTH), `count` register; per-entry valid, addr, data.
- Push: `st_valid & st_ready` writes entry at `wr_ptr`, increments `wr_ptr`.
- `st_ready` = (count < DEPTH) & (state != FLUSH); registered-state only, never depends on `mem_grant`.
- Pop: `pop = mem_req & mem_grant`; `mem_en = mem_wr = pop`; entry at `rd_ptr` invalidated, `rd_ptr` incremented.
- Count: +1 on push only, −1 on pop only, unchanged on simultaneous push+pop.
- `mem_req = (count != 0)`; `mem_addr/mem_wdata` = head entry (0 when empty).
- Forwarding: combinational compare of `ld_addr` against all valid entries; on multiple matches, youngest (nearest behind `wr_ptr`) wins. Entry being popped this cycle still counts. Store being pushed this cycle is not visible until next cycle. `ld_data` = 0 when `ld_hit` = 0.
- FSM states:
  - IDLE: on `flush_req` → FLUSH.
  - FLUSH: pushes blocked. When count == 0 (including after the final pop registers) → DONE.
  - DONE: `flush_done` = 1 for exactly one cycle → IDLE.
- `flush_req` while in FLUSH/DONE is ignored.

## Timing
- Reset (async): pointers 0, count 0, all valid 0, state IDLE. Outputs: `st_ready`=1, `mem_req`=0, `mem_en`=`mem_wr`=0, `mem_addr`=`mem_wdata`=0, `ld_hit`=0, `ld_data`=0, `flush_done`=0, `empty`=1.
- Reset mid-drain or mid-flush discards all entries; no `flush_done` is issued.
- Latency: a store pushed at edge N raises `mem_req` after edge N; earliest memory write is in cycle N+1 (given grant).
- Throughput: one push and one pop per cycle.
- Full: `st_ready`=0 at count == DEPTH, even if a pop occurs that cycle. It reasserts the cycle after the pop.
- Empty: `mem_req`=0; a grant while empty causes no write.
- Flush while empty: FLUSH for one cycle, `flush_done` in the following cycle (2 cycles after the pulse).
- Pointer wrap: pointers roll over DEPTH−1 → 0 with no bubble.

## Test plan
- Reset with `rst` asserted mid-cycle → all outputs at reset values immediately. Then push 0x0010/0xAAAA, grant held → `mem_wr`=1, addr 0x0010, data 0xAAAA one cycle later; count returns to 0.
- Grant held low, 5 stores → first 4 accepted (count=4, `st_ready`=0), 5th stalls. Raise grant → 4 writes, in order, on consecutive cycles.
- Stores 0x0020/0x1111 then 0x0020/0x2222, no grant, `ld_addr`=0x0020 → `ld_hit`=1, `ld_data`=0x2222. `ld_addr`=0x0022 → `ld_hit`=0.
- Full buffer, same-cycle `st_valid` and grant → no push that cycle, count=3; push accepted next cycle. Then alternate push/pop across ≥10 entries → pointers wrap, data order preserved.
- 3 entries, `flush_req` pulse with grant alternating → `st_ready`=0 throughout; after the 3rd write, single-cycle `flush_done`; `st_ready`=1 the cycle after.
- `flush_req` with buffer empty → `flush_done` exactly 2 cycles later; no `mem_wr`.

Source files
------------

// File: rtl/store_write_buffer.sv
// Write-through store buffer: queues EXMEM stores and drains them to memory.
// Ports: store push (st_*), drain port (mem_*), load lookup (ld_*), flush, status.
module store_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_ready,
  output logic              mem_req,
  input  logic              mem_grant,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_hit,
  output logic [DATA_W-1:0] ld_data,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              empty,
  output logic [CW-1:0]     count
);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    DONE
  } state_t;

  state_t            state;
  logic              done_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt_q;
  logic              push;
  logic              pop;

  // Depends only on registered state so the arbiter path stays short.
  assign st_ready   = (cnt_q < CW'(DEPTH)) && (state != FLUSH);
  assign push       = st_valid && st_ready;
  assign mem_req    = (cnt_q != '0);
  assign pop        = mem_req && mem_grant;
  assign mem_en     = pop;
  assign mem_wr     = pop;
  assign mem_addr   = mem_req ? addr_q[rd_ptr] : '0;
  assign mem_wdata  = mem_req ? data_q[rd_ptr] : '0;
  assign empty      = (cnt_q == '0);
  assign count      = cnt_q;
  assign flush_done = done_q;

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    ld_hit  = 1'b0;
    ld_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (vld_q[idx] && (addr_q[idx] == ld_addr)) begin
        ld_hit  = 1'b1;
        ld_data = data_q[idx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_q[wr_ptr] <= st_addr;
        data_q[wr_ptr] <= st_data;
        vld_q[wr_ptr]  <= 1'b1;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      // Push and pop never target the same slot: a push needs a free slot.
      if (pop) begin
        vld_q[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (push && !pop)
        cnt_q <= cnt_q + CW'(1);
      else if (pop && !push)
        cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (flush_req)
            state <= FLUSH;
        end
        FLUSH: begin
          if (cnt_q == '0) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed vector table,
// reset corner case, then randomized traffic against a queue model.
module tb_store_write_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic [15:0] st_addr;
  logic [15:0] st_data;
  logic        st_ready;
  logic        mem_req;
  logic        mem_grant;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] ld_addr;
  logic        ld_hit;
  logic [15:0] ld_data;
  logic        flush_req;
  logic        flush_done;
  logic        empty;
  logic [2:0]  count;

  store_write_buffer #(
    .DEPTH(DEPTH),
    .ADDR_W(16),
    .DATA_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .st_valid(st_valid),
    .st_addr(st_addr),
    .st_data(st_data),
    .st_ready(st_ready),
    .mem_req(mem_req),
    .mem_grant(mem_grant),
    .mem_en(mem_en),
    .mem_wr(mem_wr),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .ld_addr(ld_addr),
    .ld_hit(ld_hit),
    .ld_data(ld_data),
    .flush_req(flush_req),
    .flush_done(flush_done),
    .empty(empty),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    else
      passes++;
  endtask

  typedef struct {
    bit          v;
    logic [15:0] a;
    logic [15:0] d;
    bit          g;
    logic [15:0] la;
    bit          f;
    bit          e_rdy;
    bit          e_wr;
    logic [15:0] e_ha;
    logic [15:0] e_hd;
    bit          e_hit;
    logic [15:0] e_ld;
    int          e_cnt;
    bit          e_fd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(
    bit v, logic [15:0] a, logic [15:0] d, bit g, logic [15:0] la, bit f,
    bit rdy, bit wr, logic [15:0] ha, logic [15:0] hd,
    bit hit, logic [15:0] ld, int cnt, bit fd);
    vec_t r;
    r.v = v; r.a = a; r.d = d; r.g = g; r.la = la; r.f = f;
    r.e_rdy = rdy; r.e_wr = wr; r.e_ha = ha; r.e_hd = hd;
    r.e_hit = hit; r.e_ld = ld; r.e_cnt = cnt; r.e_fd = fd;
    return r;
  endfunction

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } ent_t;

  ent_t q[$];
  int   phase;

  task automatic idle_inputs();
    st_valid  = 1'b0;
    st_addr   = '0;
    st_data   = '0;
    mem_grant = 1'b0;
    ld_addr   = 16'h0FFF;
    flush_req = 1'b0;
  endtask

  initial begin
    localparam logic [15:0] N = 16'h0FFF;
    rst = 1'b1;
    idle_inputs();
    #12 rst = 1'b0;

    // Reset asserted mid-cycle while a flush is pending.
    @(negedge clk);
    st_valid = 1'b1; st_addr = 16'h0050; st_data = 16'h5555;
    @(negedge clk);
    st_addr = 16'h0060; st_data = 16'h6666; flush_req = 1'b1;
    @(negedge clk);
    idle_inputs();
    ld_addr = 16'h0050;
    #1;
    chk("pre_rst_count", 32'(count), 32'd2);
    chk("pre_rst_hit", 32'(ld_hit), 32'd1);
    mem_grant = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_ld_hit", 32'(ld_hit), 32'd0);
    chk("rst_ld_data", 32'(ld_data), 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post_rst_no_done", 32'(flush_done), 32'd0);
      @(negedge clk);
    end

    // v a d g la f | rdy wr head_a head_d hit ld cnt fd
    tbl.push_back(row(1, 16'h0010, 16'hAAAA, 1, 16'h0010, 0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0));
    tbl.push_back(row(0, 16'h0000, 16'h0000, 1, 16'h0010, 0, 1, 1, 16'h0010, 16'hAAAA, 1, 16'hAAAA, 1, 0));
    tbl.push_back(row(0, 16'h0000, 16'h0000, 0, 16'h0010, 0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0));
    tbl.push_back(row(1, 16'h0100, 16'hB000, 0, 16'h0020, 0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0));
    tbl.push_back(row(1, 16'h0101, 16'hB001, 0, 16'h0020, 0, 1, 0, 16'h0100, 16'hB000, 0, 16'h0000, 1, 0));
    tbl.push_back(row(1, 16'h0102, 16'hB002, 0, 16'h0020, 0, 1, 0, 16'h0100, 16'hB000, 0, 16'h0000, 2, 0));
    tbl.push_back(row(1, 16'h0103, 16'hB003, 0, 16'h0020, 0, 1, 0, 16'h0100, 16'hB000, 0, 16'h0000, 3, 0));
    tbl.push_back(row(1, 16'h0104, 16'hB004, 0, N,        0, 0, 0, 16'h0100, 16'hB000, 0, 16'h0000, 4, 0));
    tbl.push_back(row(1, 16'h0104, 16'hB004, 1, N,        0, 0, 1, 16'h0100, 16'hB000, 0, 16'h0000, 4, 0));
    tbl.push_back(row(1, 16'h0104, 16'hB004, 1, N,        0, 1, 1, 16'h0101, 16'hB001, 0, 16'h0000, 3, 0));
    tbl.push_back(row(0, 16'h0000, 16'h0000, 1, N,        0, 1, 1, 16'h0102, 16'hB002, 0, 16'h0000, 3, 0));
    tbl.push_back(row(0, 16'h0000, 16'h0000, 1, N,        0, 1, 1, 16'h0103, 16'hB003, 0, 16'h0000, 2, 0));
    tbl.push_back(row(0, 16'h0000, 16'h0000, 1, N,        0, 1, 1, 16'h0104, 16'hB004, 0, 16'h0000, 1, 0));
    tbl.push_back(row(0, 16'h0000, 16'h0000, 0, N,        0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0));
    tbl.push_back(row(1, 16'h0020, 16'h1111, 0, 16'h0020, 0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0));
    tbl.push_back(row(1, 16'h0020, 16'h2222, 0, 16'h0020, 0, 1, 0, 16'h0020, 16'h1111, 1, 16'h1111, 1, 0));
    tbl.push_back(row(0, 16'h0000, 16'h0000, 0, 16'h0020, 0, 1, 0, 16'h0020, 16'h1111, 1, 16'h2222, 2, 0));
    tbl.push_back(row(0, 16'h0000, 16'h0000, 0, 16'h0022, 0, 1, 0, 16'h0020, 16'h1111, 0, 16'h0000, 2, 0));
    tbl.push_back(row(1, 16'h0030, 16'h3333, 0, 16'h0020, 1, 1, 0, 16'h0020, 16'h1111, 1, 16'h2222, 2, 0));
    tbl.push_back(row(1, 16'h0040, 16'h4444, 1, 16'h0020, 0, 0, 1, 16'h0020, 16'h1111, 1, 16'h2222, 3, 0));
    tbl.push_back(row(1, 16'h0040, 16'h4444, 0, 16'h0020, 1, 0, 0, 16'h0020, 16'h2222, 1, 16'h2222, 2, 0));
    tbl.push_back(row(0, 16'h0000, 16'h0000, 1, 16'h0020, 0, 0, 1, 16'h0020, 16'h2222, 1, 16'h2222, 2, 0));
    tbl.push_back(row(0, 16'h0000, 16'h0000, 0, 16'h0020, 0, 0, 0, 16'h0030, 16'h3333, 0, 16'h0000, 1, 0));
    tbl.push_back(row(0, 16'h0000, 16'h0000, 1, N,        0, 0, 1, 16'h0030, 16'h3333, 0, 16'h0000, 1, 0));
    tbl.push_back(row(0, 16'h0000, 16'h0000, 1, N,        0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0));
    tbl.push_back(row(0, 16'h0000, 16'h0000, 0, N,        0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 1));
    tbl.push_back(row(0, 16'h0000, 16'h0000, 0, N,        0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0));
    tbl.push_back(row(0, 16'h0000, 16'h0000, 0, N,        1, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0));
    tbl.push_back(row(0, 16'h0000, 16'h0000, 1, N,        0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0));
    tbl.push_back(row(0, 16'h0000, 16'h0000, 0, N,        0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 1));
    tbl.push_back(row(0, 16'h0000, 16'h0000, 0, N,        0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0));

    foreach (tbl[i]) begin
      st_valid  = tbl[i].v;
      st_addr   = tbl[i].a;
      st_data   = tbl[i].d;
      mem_grant = tbl[i].g;
      ld_addr   = tbl[i].la;
      flush_req = tbl[i].f;
      #1;
      chk($sformatf("v%0d_st_ready", i), 32'(st_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("v%0d_mem_wr", i), 32'(mem_wr), 32'(tbl[i].e_wr));
      chk($sformatf("v%0d_mem_en", i), 32'(mem_en), 32'(tbl[i].e_wr));
      chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].e_ha));
      chk($sformatf("v%0d_mem_wdata", i), 32'(mem_wdata), 32'(tbl[i].e_hd));
      chk($sformatf("v%0d_ld_hit", i), 32'(ld_hit), 32'(tbl[i].e_hit));
      chk($sformatf("v%0d_ld_data", i), 32'(ld_data), 32'(tbl[i].e_ld));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(tbl[i].e_cnt != 0));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].e_cnt == 0));
      chk($sformatf("v%0d_flush_done", i), 32'(flush_done), 32'(tbl[i].e_fd));
      @(negedge clk);
    end

    // Randomized traffic against a queue model; buffer is empty and idle here.
    q.delete();
    phase = 0;
    for (int n = 0; n < 3000; n++) begin
      bit          x_rdy;
      bit          x_wr;
      bit          x_hit;
      logic [15:0] x_ha;
      logic [15:0] x_hd;
      logic [15:0] x_ld;
      ent_t        e;
      st_valid  = 1'($urandom_range(0, 1));
      st_addr   = 16'($urandom_range(0, 7));
      st_data   = 16'($urandom);
      mem_grant = ($urandom_range(0, 2) == 0);
      ld_addr   = 16'($urandom_range(0, 7));
      flush_req = ($urandom_range(0, 39) == 0);
      #1;
      x_rdy = (q.size() < DEPTH) && (phase != 1);
      x_wr  = (q.size() != 0) && mem_grant;
      x_ha  = (q.size() != 0) ? q[0].a : 16'h0;
      x_hd  = (q.size() != 0) ? q[0].d : 16'h0;
      x_hit = 1'b0;
      x_ld  = 16'h0;
      for (int k = q.size() - 1; k >= 0; k--) begin
        if (q[k].a == ld_addr) begin
          x_hit = 1'b1;
          x_ld  = q[k].d;
          break;
        end
      end
      chk("rnd_st_ready", 32'(st_ready), 32'(x_rdy));
      chk("rnd_mem_wr", 32'(mem_wr), 32'(x_wr));
      chk("rnd_mem_addr", 32'(mem_addr), 32'(x_ha));
      chk("rnd_mem_wdata", 32'(mem_wdata), 32'(x_hd));
      chk("rnd_ld_hit", 32'(ld_hit), 32'(x_hit));
      chk("rnd_ld_data", 32'(ld_data), 32'(x_ld));
      chk("rnd_count", 32'(count), 32'(q.size()));
      chk("rnd_flush_done", 32'(flush_done), 32'(phase == 2));
      @(posedge clk);
      if (phase == 0 && flush_req)
        phase = 1;
      else if (phase == 1 && q.size() == 0)
        phase = 2;
      else if (phase == 2)
        phase = 0;
      if (x_wr)
        void'(q.pop_front());
      if (st_valid && x_rdy) begin
        e.a = st_addr;
        e.d = st_data;
        q.push_back(e);
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
